// File: rtl/rot_wb_stage.sv
// rot_wb_stage
//   Writeback stage behind the rotate-right unit. Captures the rotated result,
//   its destination register index and the Z/N(/C) flags into a two-entry skid
//   buffer. It presents a valid/ready stream to the register file and sustains
//   one result per cycle.
//
//   Optional feature macro: ROT_WB_CARRY_EN
//     When defined, a carry flag (the last bit rotated out) is stored with
//     each result and driven on out_c.
//     When undefined, out_c is tied 0 and no carry flops exist.
//
//   Ports
//     clock      rising-edge clock
//     clear      asynchronous active-low reset
//     flush      synchronous discard of all buffered results
//     in_valid   upstream handshake, valid
//     in_ready   upstream handshake, ready (registered)
//     in_data    rotator result
//     in_count   rotate count
//     in_dest    destination register index
//     out_valid  downstream handshake, valid (registered)
//     out_ready  downstream handshake, ready
//     out_data   buffered result
//     out_dest   buffered destination index
//     out_z      result flag: zero
//     out_n      result flag: negative
//     out_c      result flag: carry
//     rf_we      register-file write enable, equal to out_valid & out_ready
module rot_wb_stage #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CNT_W-1:0]  in_count,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_z,
  output logic              out_n,
  output logic              out_c,
  output logic              rf_we
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [DEST_W-1:0]  main_dest_q, main_dest_d;
  logic               main_z_q, main_z_d;
  logic               main_n_q, main_n_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [DEST_W-1:0]  skid_dest_q, skid_dest_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               push, pop;

`ifdef ROT_WB_CARRY_EN
  logic main_c_q, main_c_d;
  logic skid_c_q, skid_c_d;
  logic in_c;
  // The last bit shifted out by a rotate-right lands in the MSB.
  assign in_c = (in_count != '0) ? in_data[WIDTH-1] : 1'b0;
`else
  logic unused_count;
  assign unused_count = ^in_count;
`endif

  assign push  = in_valid & in_ready_q;
  assign pop   = out_valid_q & out_ready;
  assign rf_we = pop;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_dest_d = main_dest_q;
    main_z_d    = main_z_q;
    main_n_d    = main_n_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
`ifdef ROT_WB_CARRY_EN
    main_c_d    = main_c_q;
    skid_c_d    = skid_c_q;
`endif
    if (flush) begin
      state_d     = S_EMPTY;
      main_data_d = '0;
      main_dest_d = '0;
      main_z_d    = 1'b0;
      main_n_d    = 1'b0;
`ifdef ROT_WB_CARRY_EN
      main_c_d    = 1'b0;
      skid_c_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_EMPTY: if (push) state_d = S_ONE;
        S_ONE: begin
          if (push && !pop)      state_d = S_FULL;
          else if (!push && pop) state_d = S_EMPTY;
        end
        S_FULL: if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase

      // The main register loads from the input whenever a push would land in
      // an empty main slot. It loads from skid when FULL drains.
      if (push && (state_q == S_EMPTY || (state_q == S_ONE && pop))) begin
        main_data_d = in_data;
        main_dest_d = in_dest;
        main_z_d    = (in_data == '0);
        main_n_d    = in_data[WIDTH-1];
`ifdef ROT_WB_CARRY_EN
        main_c_d    = in_c;
`endif
      end else if (push && state_q == S_ONE) begin
        skid_data_d = in_data;
        skid_dest_d = in_dest;
`ifdef ROT_WB_CARRY_EN
        skid_c_d    = in_c;
`endif
      end else if (pop && state_q == S_FULL) begin
        main_data_d = skid_data_q;
        main_dest_d = skid_dest_q;
        main_z_d    = (skid_data_q == '0);
        main_n_d    = skid_data_q[WIDTH-1];
`ifdef ROT_WB_CARRY_EN
        main_c_d    = skid_c_q;
`endif
      end
    end
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_FULL);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_dest_q <= '0;
      main_z_q    <= 1'b0;
      main_n_q    <= 1'b0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_dest_q <= main_dest_d;
      main_z_q    <= main_z_d;
      main_n_q    <= main_n_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef ROT_WB_CARRY_EN
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      main_c_q <= 1'b0;
      skid_c_q <= 1'b0;
    end else begin
      main_c_q <= main_c_d;
      skid_c_q <= skid_c_d;
    end
  end
  assign out_c = main_c_q;
`else
  assign out_c = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_dest  = main_dest_q;
  assign out_z     = main_z_q;
  assign out_n     = main_n_q;

endmodule

// File: tb/tb_rot_wb_stage.sv
// tb_rot_wb_stage
//   Directed, table-driven checks of rot_wb_stage, followed by hand-written
//   sequences for streaming, flush and a mid-stream reset.
module tb_rot_wb_stage;

`ifdef ROT_WB_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_count;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_dest;
  logic        out_z, out_n, out_c, rf_we;

  int ncmp  = 0;
  int nfail = 0;

  rot_wb_stage #(.WIDTH(32), .DEST_W(4), .CNT_W(5)) dut (
    .clock(clock), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_count(in_count), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_z(out_z), .out_n(out_n), .out_c(out_c),
    .rf_we(rf_we)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] data;
    logic [4:0]  count;
    logic [3:0]  dest;
    logic        out_ready;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_data;
    logic [3:0]  e_dest;
    logic        e_z;
    logic        e_n;
    logic        e_c;
    logic        e_we;
  } vec_t;

  vec_t vecs[12];

  task automatic drive(input logic f, input logic v, input logic [31:0] d,
                       input logic [4:0] c, input logic [3:0] t, input logic r);
    flush = f; in_valid = v; in_data = d; in_count = c; in_dest = t; out_ready = r;
  endtask

  initial begin
    //            flush vld data          cnt dst rdy | vld rdy data          dst z n c we
    vecs[0]  = '{1'b0,1'b1,32'h8000_0001,5'd1,4'd3,1'b1, 1'b1,1'b1,32'h8000_0001,4'd3,1'b0,1'b1,1'b1,1'b1};
    vecs[1]  = '{1'b0,1'b0,32'h0,        5'd0,4'd0,1'b1, 1'b0,1'b1,32'h0,        4'd0,1'b0,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,32'h0000_0011,5'd0,4'd1,1'b0, 1'b1,1'b1,32'h0000_0011,4'd1,1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,32'hF000_0000,5'd4,4'd2,1'b0, 1'b1,1'b0,32'h0000_0011,4'd1,1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,32'h1234_5678,5'd3,4'd5,1'b0, 1'b1,1'b0,32'h0000_0011,4'd1,1'b0,1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,32'h1234_5678,5'd3,4'd5,1'b1, 1'b1,1'b1,32'hF000_0000,4'd2,1'b0,1'b1,1'b1,1'b1};
    vecs[6]  = '{1'b0,1'b1,32'h1234_5678,5'd3,4'd5,1'b1, 1'b1,1'b1,32'h1234_5678,4'd5,1'b0,1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b0,32'h0,        5'd0,4'd0,1'b1, 1'b0,1'b1,32'h0,        4'd0,1'b0,1'b0,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,32'h0000_0000,5'd0,4'd7,1'b0, 1'b1,1'b1,32'h0000_0000,4'd7,1'b1,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b0,1'b1,32'hAAAA_0000,5'd2,4'd9,1'b0, 1'b1,1'b0,32'h0000_0000,4'd7,1'b1,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b1,32'h0000_5555,5'd1,4'd4,1'b0, 1'b0,1'b1,32'h0,        4'd0,1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b0,1'b0,32'h0,        5'd0,4'd0,1'b1, 1'b0,1'b1,32'h0,        4'd0,1'b0,1'b0,1'b0,1'b0};

    clear = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset out_data",  out_data,           32'd0);
    chk("reset rf_we",     {31'b0, rf_we},     32'd0);
    clear = 1'b1;

    for (int unsigned i = 0; i < 12; i++) begin
      drive(vecs[i].flush, vecs[i].in_valid, vecs[i].data, vecs[i].count,
            vecs[i].dest, vecs[i].out_ready);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].e_ready});
      chk($sformatf("v%0d rf_we", i),     {31'b0, rf_we},     {31'b0, vecs[i].e_we});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_data);
        chk($sformatf("v%0d out_dest", i), {28'b0, out_dest}, {28'b0, vecs[i].e_dest});
        chk($sformatf("v%0d out_z", i), {31'b0, out_z}, {31'b0, vecs[i].e_z});
        chk($sformatf("v%0d out_n", i), {31'b0, out_n}, {31'b0, vecs[i].e_n});
        chk($sformatf("v%0d out_c", i), {31'b0, out_c}, {31'b0, vecs[i].e_c & CARRY});
      end
    end

    // Streaming: eight back-to-back results retire on consecutive cycles.
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b0, 1'b1, 32'h100 + i, 5'd1, 4'(i), 1'b1);
      else       drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
      @(posedge clock);
      #1;
      if (i < 8) begin
        chk($sformatf("stream%0d rf_we", i), {31'b0, rf_we}, 32'd1);
        chk($sformatf("stream%0d data", i), out_data, 32'h100 + i);
        chk($sformatf("stream%0d dest", i), {28'b0, out_dest}, i);
      end else begin
        chk("stream end rf_we", {31'b0, rf_we}, 32'd0);
      end
    end

    // Flush while a result is being retired: rf_we follows current handshake.
    drive(1'b0, 1'b1, 32'h77, 5'd1, 4'd1, 1'b0);
    @(posedge clock);
    #1;
    drive(1'b1, 1'b1, 32'h99, 5'd1, 4'd2, 1'b1);
    #1;
    chk("flush cycle rf_we", {31'b0, rf_we}, 32'd1);
    @(posedge clock);
    #1;
    chk("post flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("post flush in_ready",  {31'b0, in_ready},  32'd1);
    chk("post flush rf_we",     {31'b0, rf_we},     32'd0);
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);

    // Mid-stream reset: buffered results vanish and never retire.
    drive(1'b0, 1'b1, 32'hABCD, 5'd1, 4'd6, 1'b0);
    @(posedge clock);
    #1;
    drive(1'b0, 1'b1, 32'hBCDE, 5'd1, 4'd7, 1'b0);
    @(posedge clock);
    #1;
    chk("pre reset full in_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
    #2 clear = 1'b0;
    #1;
    chk("midreset out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset in_ready",  {31'b0, in_ready},  32'd1);
    chk("midreset out_data",  out_data,           32'd0);
    chk("midreset rf_we",     {31'b0, rf_we},     32'd0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk($sformatf("after reset%0d rf_we", i), {31'b0, rf_we}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
